// File: rtl/core_inst_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_inst_ctrl_if
//   Bundles the instruction word, the OFIFO/L0 status inputs and every decoded
//   control output of core_inst_ctrl.
//   master : instruction source (drives inst, ofifo_valid, l0_full)
//   slave  : core_inst_ctrl (drives SRAM controls, strobes, phase, err)
//   When INST_CTRL_PERF_EN is defined, the exec_cycles / stall_cycles
//   counters are carried as extra slave outputs.
// ---------------------------------------------------------------------------
interface core_inst_ctrl_if #(
  parameter int addr_w = 11
);
  logic [33:0]       inst;
  logic              ofifo_valid;
  logic              l0_full;

  logic              xmem_cen;
  logic              xmem_wen;
  logic [addr_w-1:0] xmem_a;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [addr_w-1:0] pmem_a;
  logic              l0_wr;
  logic              l0_rd;
  logic              ififo_wr;
  logic              ififo_rd;
  logic              ofifo_rd;
  logic              pe_load;
  logic              pe_execute;
  logic              sfp_acc;
  logic [2:0]        phase;
  logic              err;
  logic [2:0]        err_code;

`ifdef INST_CTRL_PERF_EN
  logic [31:0]       exec_cycles;
  logic [31:0]       stall_cycles;

  modport master (
    output inst, ofifo_valid, l0_full,
    input  xmem_cen, xmem_wen, xmem_a, pmem_cen, pmem_wen, pmem_a,
           l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd,
           pe_load, pe_execute, sfp_acc, phase, err, err_code,
           exec_cycles, stall_cycles
  );
  modport slave (
    input  inst, ofifo_valid, l0_full,
    output xmem_cen, xmem_wen, xmem_a, pmem_cen, pmem_wen, pmem_a,
           l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd,
           pe_load, pe_execute, sfp_acc, phase, err, err_code,
           exec_cycles, stall_cycles
  );
`else
  modport master (
    output inst, ofifo_valid, l0_full,
    input  xmem_cen, xmem_wen, xmem_a, pmem_cen, pmem_wen, pmem_a,
           l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd,
           pe_load, pe_execute, sfp_acc, phase, err, err_code
  );
  modport slave (
    input  inst, ofifo_valid, l0_full,
    output xmem_cen, xmem_wen, xmem_a, pmem_cen, pmem_wen, pmem_a,
           l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd,
           pe_load, pe_execute, sfp_acc, phase, err, err_code
  );
`endif
endinterface

// File: rtl/core_inst_ctrl.sv
// ---------------------------------------------------------------------------
// core_inst_ctrl
//   Registers the 34-bit core instruction word and decodes it into xmem/pmem
//   SRAM controls, L0/IFIFO/OFIFO strobes, PE load/execute and SFP acc
//   enables. An FSM tracks the kernel-load / flush / execute / drain /
//   accumulate phase, and a sticky flag records the first protocol error.
//
//   Ports
//     clk    : clock, rising edge
//     reset  : synchronous, active-low
//     bus    : core_inst_ctrl_if.slave (inst, ofifo_valid, l0_full in;
//              SRAM controls, strobes, phase, err, err_code out)
//
//   inst layout: [33]acc [32]CEN_p [31]WEN_p [30:20]A_p [19]CEN_x [18]WEN_x
//                [17:7]A_x [6]ofifo_rd [5]ififo_wr [4]ififo_rd [3]l0_rd
//                [2]l0_wr [1]execute [0]load
//
//   Optional: define INST_CTRL_PERF_EN to add exec_cycles / stall_cycles.
// ---------------------------------------------------------------------------
module core_inst_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int addr_w   = 11,
  parameter int sram_lat = 1
) (
  input  logic            clk,
  input  logic            reset,
  core_inst_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KLOAD  = 3'd1,
    KFLUSH = 3'd2,
    EXEC   = 3'd3,
    DRAIN  = 3'd4,
    ACC    = 3'd5
  } phase_e;

  localparam int FW = $clog2(row + 1);
  localparam int KW = $clog2(col + row + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(row - 1);
  localparam logic [KW-1:0] KLOAD_MAX  = KW'(col + row);

  // Instruction field decode
  logic acc_i, load_i, exec_i, l0_wr_i;
  assign acc_i   = bus.inst[33];
  assign l0_wr_i = bus.inst[2];
  assign exec_i  = bus.inst[1];
  assign load_i  = bus.inst[0];

  // Registered decode stage
  logic              xmem_cen_q, xmem_wen_q, pmem_cen_q, pmem_wen_q;
  logic [addr_w-1:0] xmem_a_q, pmem_a_q;
  logic              l0_rd_q, ififo_wr_q, ififo_rd_q, ofifo_rd_q;
  logic              pe_load_q, pe_execute_q, sfp_acc_q;
  // l0_wr rides an extra sram_lat stages so it lines up with xmem read data.
  logic [sram_lat:0] l0_wr_pipe_q;

  phase_e            state_q, state_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic [KW-1:0]     kload_cnt_q, kload_cnt_d;

  logic              err_q;
  logic [2:0]        err_code_q;
  logic [5:1]        err_hit;
  logic [2:0]        first_code;

  // Output-side gating, evaluated against the status seen in the output cycle
  logic l0_wr_gated, ofifo_rd_gated;
  assign l0_wr_gated    = l0_wr_pipe_q[sram_lat] & bus.l0_full;
  assign ofifo_rd_gated = ofifo_rd_q & ~bus.ofifo_valid;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its sources regardless of statement order; reset is
  // synchronous, so it lives inside the clocked branch rather than the
  // sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      xmem_cen_q   <= 1'b1;
      xmem_wen_q   <= 1'b1;
      pmem_cen_q   <= 1'b1;
      pmem_wen_q   <= 1'b1;
      xmem_a_q     <= '0;
      pmem_a_q     <= '0;
      l0_rd_q      <= 1'b0;
      ififo_wr_q   <= 1'b0;
      ififo_rd_q   <= 1'b0;
      ofifo_rd_q   <= 1'b0;
      pe_load_q    <= 1'b0;
      pe_execute_q <= 1'b0;
      sfp_acc_q    <= 1'b0;
      l0_wr_pipe_q <= '0;
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      kload_cnt_q  <= '0;
      err_q        <= 1'b0;
      err_code_q   <= 3'd0;
    end else begin
      xmem_cen_q   <= bus.inst[19];
      xmem_wen_q   <= bus.inst[18];
      xmem_a_q     <= addr_w'(bus.inst[17:7]);
      pmem_cen_q   <= bus.inst[32];
      pmem_wen_q   <= bus.inst[31];
      pmem_a_q     <= addr_w'(bus.inst[30:20]);
      l0_rd_q      <= bus.inst[3];
      ififo_rd_q   <= bus.inst[4];
      ififo_wr_q   <= bus.inst[5];
      ofifo_rd_q   <= bus.inst[6];
      // Simultaneous load and execute is ambiguous: drive neither.
      pe_load_q    <= load_i & ~exec_i;
      pe_execute_q <= exec_i & ~load_i;
      sfp_acc_q    <= acc_i;
      l0_wr_pipe_q[0] <= l0_wr_i;
      for (int i = 1; i <= sram_lat; i++) begin
        l0_wr_pipe_q[i] <= l0_wr_pipe_q[i-1];
      end
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      kload_cnt_q  <= kload_cnt_d;
      // Only the first error is kept; later ones never overwrite the code.
      if (!err_q && (|err_hit)) begin
        err_q      <= 1'b1;
        err_code_q <= first_code;
      end
    end
  end

  // NOTE: every always_comb target gets a default before any branching, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    kload_cnt_d = kload_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d     = KLOAD;
          kload_cnt_d = '0;
        end else if (exec_i) begin
          state_d = EXEC;
        end else if (acc_i) begin
          state_d = ACC;
        end
      end
      KLOAD: begin
        if (kload_cnt_q != KLOAD_MAX) kload_cnt_d = kload_cnt_q + 1'b1;
        if (!load_i) begin
          state_d     = KFLUSH;
          flush_cnt_d = '0;
        end
      end
      KFLUSH: begin
        // An early execute is honoured (and flagged) rather than dropped.
        if (exec_i)                          state_d = EXEC;
        else if (flush_cnt_q == FLUSH_LAST)  state_d = IDLE;
        else                                 flush_cnt_d = flush_cnt_q + 1'b1;
      end
      EXEC:    if (!exec_i)          state_d = DRAIN;
      DRAIN:   if (!bus.ofifo_valid) state_d = IDLE;
      ACC:     if (!acc_i)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error detection; the lowest code wins when several fire together.
  always_comb begin
    err_hit[1] = load_i & exec_i;
    err_hit[2] = exec_i & (state_q == KFLUSH);
    err_hit[3] = l0_wr_gated;
    err_hit[4] = ofifo_rd_gated;
    err_hit[5] = acc_i & ((state_q == EXEC) || (state_q == DRAIN));
    first_code = 3'd0;
    for (int c = 5; c >= 1; c--) begin
      if (err_hit[c]) first_code = 3'(c);
    end
  end

  assign bus.xmem_cen   = xmem_cen_q;
  assign bus.xmem_wen   = xmem_wen_q;
  assign bus.xmem_a     = xmem_a_q;
  assign bus.pmem_cen   = pmem_cen_q;
  assign bus.pmem_wen   = pmem_wen_q;
  assign bus.pmem_a     = pmem_a_q;
  assign bus.l0_wr      = l0_wr_pipe_q[sram_lat] & ~bus.l0_full;
  assign bus.l0_rd      = l0_rd_q;
  assign bus.ififo_wr   = ififo_wr_q;
  assign bus.ififo_rd   = ififo_rd_q;
  assign bus.ofifo_rd   = ofifo_rd_q & bus.ofifo_valid;
  assign bus.pe_load    = pe_load_q;
  assign bus.pe_execute = pe_execute_q;
  assign bus.sfp_acc    = sfp_acc_q;
  assign bus.phase      = state_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

`ifdef INST_CTRL_PERF_EN
  logic [31:0] exec_cycles_q, stall_cycles_q;
  logic        pe_clash_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      exec_cycles_q  <= '0;
      stall_cycles_q <= '0;
      pe_clash_q     <= 1'b0;
    end else begin
      pe_clash_q     <= load_i & exec_i;
      exec_cycles_q  <= exec_cycles_q + 32'(state_q == EXEC);
      stall_cycles_q <= stall_cycles_q
                        + 32'(l0_wr_gated | ofifo_rd_gated | pe_clash_q);
    end
  end

  assign bus.exec_cycles  = exec_cycles_q;
  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_core_inst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_inst_ctrl
//   Directed stimulus for core_inst_ctrl. The driver applies one instruction
//   per cycle (just after the rising edge) and pushes the expected outputs,
//   stamped with the cycle they must appear in, onto a scoreboard queue. A
//   monitor samples the DUT on every falling edge and retires the entries
//   due in that cycle.
// ---------------------------------------------------------------------------
module tb_core_inst_ctrl;

  localparam logic [33:0] I_LOAD = 34'h0_0000_0001;
  localparam logic [33:0] I_EXEC = 34'h0_0000_0002;
  localparam logic [33:0] I_L0WR = 34'h0_0000_0004;
  localparam logic [33:0] I_OFRD = 34'h0_0000_0040;
  localparam logic [33:0] I_WENX = 34'h0_0004_0000;
  localparam logic [33:0] I_CENX = 34'h0_0008_0000;
  localparam logic [33:0] I_WENP = 34'h0_8000_0000;
  localparam logic [33:0] I_CENP = 34'h1_0000_0000;
  localparam logic [33:0] I_ACC  = 34'h2_0000_0000;
  localparam logic [33:0] I_NOP  = I_CENP | I_WENP | I_CENX | I_WENX;

  typedef enum {
    S_PHASE, S_ERR, S_CODE, S_PELOAD, S_PEEXEC,
    S_L0WR, S_OFRD, S_XA, S_XCEN, S_SFP
  } sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  core_inst_ctrl_if #(.addr_w(11)) bus();

  core_inst_ctrl #(.row(8), .col(8), .addr_w(11), .sram_lat(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_PHASE:  return 32'(bus.phase);
      S_ERR:    return 32'(bus.err);
      S_CODE:   return 32'(bus.err_code);
      S_PELOAD: return 32'(bus.pe_load);
      S_PEEXEC: return 32'(bus.pe_execute);
      S_L0WR:   return 32'(bus.l0_wr);
      S_OFRD:   return 32'(bus.ofifo_rd);
      S_XA:     return 32'(bus.xmem_a);
      S_XCEN:   return 32'(bus.xmem_cen);
      default:  return 32'(bus.sfp_acc);
    endcase
  endfunction

  task automatic check(input logic ok, input string nm);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cyc=%0d", nm, cyc);
    end
  endtask

  // Expect signal s to equal v, dly cycles after the instruction just driven.
  task automatic expect_at(input int dly, input sig_e s, input logic [31:0] v,
                           input string nm);
    sb.push_back('{cyc + dly, s, v, nm});
  endtask

  task automatic drive(input logic [33:0] i, input logic ofv = 1'b0,
                       input logic full = 1'b0, input logic rst = 1'b1);
    @(posedge clk);
    #1;
    bus.inst        = i;
    bus.ofifo_valid = ofv;
    bus.l0_full     = full;
    reset           = rst;
  endtask

  task automatic do_reset();
    drive(I_NOP, 1'b0, 1'b0, 1'b0);
    expect_at(1, S_ERR,   0, "rst_err");
    expect_at(1, S_CODE,  0, "rst_code");
    expect_at(1, S_PHASE, 0, "rst_phase");
    drive(I_NOP);
  endtask

  // Monitor: retire every scoreboard entry due in the current cycle.
  initial begin
    logic [31:0] act;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          act = sample(sb[i].sig);
          if (sb[i].cyc < cyc || act !== sb[i].val)
            $display("  %s: got %0h, expected %0h (due cyc %0d)",
                     sb[i].name, act, sb[i].val, sb[i].cyc);
          check(sb[i].cyc == cyc && act === sb[i].val, sb[i].name);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    reset           = 1'b0;
    bus.inst        = I_NOP;
    bus.ofifo_valid = 1'b0;
    bus.l0_full     = 1'b0;

    // 1: reset held with random instructions
    for (int k = 0; k < 10; k++) begin
      r = {$urandom(), $urandom()};
      drive(r[33:0], 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
      expect_at(1, S_PHASE,  0, "t1_phase");
      expect_at(1, S_ERR,    0, "t1_err");
      expect_at(1, S_CODE,   0, "t1_code");
      expect_at(1, S_XCEN,   1, "t1_xcen");
      expect_at(1, S_XA,     0, "t1_xa");
      expect_at(1, S_L0WR,   0, "t1_l0wr");
      expect_at(1, S_PELOAD, 0, "t1_peload");
      expect_at(1, S_OFRD,   0, "t1_ofrd");
    end
    drive(I_NOP);
    drive(I_NOP);

    // 2: kernel load for 8 cycles, then 8-cycle flush, then idle
    for (int k = 0; k < 8; k++) begin
      drive(I_NOP | I_LOAD);
      expect_at(1, S_PHASE,  1, "t2_kload");
      expect_at(1, S_PELOAD, 1, "t2_peload");
    end
    for (int k = 0; k < 8; k++) begin
      drive(I_NOP);
      expect_at(1, S_PHASE,  2, "t2_kflush");
      expect_at(1, S_PELOAD, 0, "t2_peload_off");
    end
    drive(I_NOP);
    expect_at(1, S_PHASE, 0, "t2_idle");

    // 3: L0 writes with xmem addresses 0..4
    for (int a = 0; a < 5; a++) begin
      drive((I_NOP & ~I_CENX) | I_L0WR | (34'(a) << 7));
      expect_at(1, S_XA,   32'(a), "t3_xa");
      expect_at(1, S_XCEN, 0,      "t3_xcen");
      expect_at(2, S_L0WR, 1,      "t3_l0wr");
    end
    drive(I_NOP);
    expect_at(1, S_XCEN, 1, "t3_xcen_off");
    expect_at(2, S_L0WR, 0, "t3_l0wr_off");
    drive(I_NOP);

    // 5: execute 10 cycles, OFIFO valid for 3 more, then drained
    for (int k = 0; k < 10; k++) begin
      drive(I_NOP | I_EXEC, 1'b1);
      expect_at(1, S_PHASE,  3, "t5_exec");
      expect_at(1, S_PEEXEC, 1, "t5_peexec");
    end
    drive(I_NOP, 1'b1);
    expect_at(1, S_PHASE,  4, "t5_drain0");
    expect_at(1, S_PEEXEC, 0, "t5_peexec_off");
    drive(I_NOP | I_OFRD, 1'b1);
    expect_at(1, S_PHASE, 4, "t5_drain1");
    expect_at(1, S_OFRD,  1, "t5_ofrd");
    drive(I_NOP, 1'b1);
    expect_at(1, S_PHASE, 4, "t5_drain2");
    drive(I_NOP, 1'b0);
    expect_at(1, S_PHASE, 0, "t5_idle");
    expect_at(1, S_ERR,   0, "t5_noerr");
    drive(I_NOP);

    // 4: L0 write while full -> gated, error 3; later load&execute keeps 3
    drive((I_NOP & ~I_CENX) | I_L0WR, 1'b0, 1'b1);
    expect_at(2, S_L0WR, 0, "t4_l0wr_gated");
    expect_at(2, S_ERR,  0, "t4_err_pre");
    expect_at(3, S_ERR,  1, "t4_err");
    expect_at(3, S_CODE, 3, "t4_code3");
    for (int k = 0; k < 3; k++) drive(I_NOP, 1'b0, 1'b1);
    drive(I_NOP | I_LOAD | I_EXEC);
    expect_at(1, S_PELOAD, 0, "t4_peload");
    expect_at(1, S_PEEXEC, 0, "t4_peexec");
    expect_at(1, S_CODE,   3, "t4_code_kept");
    drive(I_NOP);
    do_reset();

    // 6: load&execute -> both gated, error 1, load wins the FSM
    drive(I_NOP | I_LOAD | I_EXEC);
    expect_at(1, S_PELOAD, 0, "t6_peload");
    expect_at(1, S_PEEXEC, 0, "t6_peexec");
    expect_at(1, S_ERR,    1, "t6_err");
    expect_at(1, S_CODE,   1, "t6_code1");
    expect_at(1, S_PHASE,  1, "t6_kload");
    drive(I_NOP);
    do_reset();
    check(bus.err === 1'b0,      "t6_rst_err_clear");
    check(bus.err_code === 3'd0, "t6_rst_code_clear");
    check(bus.phase === 3'd0,    "t6_rst_phase_idle");
    check(bus.xmem_cen === 1'b1, "t6_rst_xcen");
    check(bus.pe_load === 1'b0,  "t6_rst_peload");

    // execute during KFLUSH -> forwarded, EXEC, error 2
    drive(I_NOP | I_LOAD);
    drive(I_NOP);
    expect_at(1, S_PHASE, 2, "e2_kflush");
    drive(I_NOP | I_EXEC);
    expect_at(1, S_PHASE,  3, "e2_exec");
    expect_at(1, S_PEEXEC, 1, "e2_peexec");
    expect_at(1, S_CODE,   2, "e2_code2");
    drive(I_NOP);
    expect_at(1, S_PHASE, 4, "e2_drain");
    drive(I_NOP);
    expect_at(1, S_PHASE, 0, "e2_idle");
    do_reset();

    // errors 4 and 1 in the same cycle -> lowest code latched
    drive(I_NOP | I_OFRD);
    expect_at(1, S_OFRD, 0, "sim_ofrd_gated");
    drive(I_NOP | I_LOAD | I_EXEC);
    expect_at(1, S_CODE, 1, "sim_code1");
    drive(I_NOP);
    do_reset();

    // error 4 alone
    drive(I_NOP | I_OFRD);
    expect_at(1, S_OFRD, 0, "e4_ofrd_gated");
    expect_at(1, S_ERR,  0, "e4_err_pre");
    expect_at(2, S_CODE, 4, "e4_code4");
    drive(I_NOP);
    drive(I_NOP);
    do_reset();

    // accumulate phase, then acc during EXEC -> error 5
    for (int k = 0; k < 3; k++) begin
      drive(I_NOP | I_ACC);
      expect_at(1, S_PHASE, 5, "acc_phase");
      expect_at(1, S_SFP,   1, "acc_sfp");
    end
    drive(I_NOP);
    expect_at(1, S_PHASE, 0, "acc_idle");
    expect_at(1, S_SFP,   0, "acc_sfp_off");
    expect_at(1, S_ERR,   0, "acc_noerr");
    drive(I_NOP | I_EXEC);
    expect_at(1, S_PHASE, 3, "e5_exec");
    drive(I_NOP | I_ACC);
    expect_at(1, S_PHASE, 4, "e5_drain");
    expect_at(1, S_CODE,  5, "e5_code5");
    drive(I_NOP);
    expect_at(1, S_PHASE, 0, "e5_idle");

    for (int k = 0; k < 4; k++) drive(I_NOP);
    @(negedge clk);
    #1;
    while (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: never checked (due cyc %0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
